// File: rtl/axi2wb.sv
// axi2wb - AXI4 slave to Wishbone B4 master bridge.
//
// Accepts one AXI4 read or write burst at a time. Reads and writes are
// granted round-robin. Each burst is replayed beat by beat as Wishbone
// classic cycles, with cycle-type hints for incrementing bursts.
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*    AXI4 write address, data and response channels
//   s_axi_ar*/r*       AXI4 read address and data channels
//   wb_*_o / wb_*_i    Wishbone B4 master towards the shared bus
module axi2wb #(
    parameter int ID_W = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [AW-1:0]     s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,

    input  logic [DW-1:0]     s_axi_wdata,
    input  logic [DW/8-1:0]   s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,

    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,

    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [AW-1:0]     s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,

    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DW-1:0]     s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,

    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_DATA = 3'd1;
    localparam logic [2:0] WR_WB   = 3'd2;
    localparam logic [2:0] WR_RESP = 3'd3;
    localparam logic [2:0] RD_WB   = 3'd4;
    localparam logic [2:0] RD_DATA = 3'd5;

    logic [2:0]      state;
    logic            prio_w;
    logic [ID_W-1:0] id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [1:0]      burst;
    logic [7:0]      beat;
    logic            err_flag;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            retry;     // stb held low for the one cycle after rty
    logic            in_burst;  // keeps cyc asserted between beats of a burst

    logic            aw_grant;
    logic            ar_grant;
    logic            wb_phase;
    logic            beat_last;
    logic            wb_done;
    logic [AW-1:0]   addr_inc;
    logic [AW-1:0]   wrap_mask;
    logic [AW-1:0]   addr_next;

    // Size and wlast are irrelevant: lanes come from wstrb, beat count from len.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_arsize, s_axi_wlast};

    assign aw_grant  = !rst && (state == IDLE) && s_axi_awvalid && (!s_axi_arvalid || prio_w);
    assign ar_grant  = !rst && (state == IDLE) && s_axi_arvalid && (!s_axi_awvalid || !prio_w);
    assign wb_phase  = (state == WR_WB) || (state == RD_WB);
    assign beat_last = (beat == len);
    // An ack/err only counts while stb is actually presented.
    assign wb_done   = wb_phase && !retry && (wb_ack_i || wb_err_i);

    always_comb begin
        addr_inc  = addr + AW'(4);
        wrap_mask = AW'({len, 2'b11});
        case (burst)
            2'b00:   addr_next = addr;
            2'b10:   addr_next = (addr & ~wrap_mask) | (addr_inc & wrap_mask);
            default: addr_next = addr_inc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prio_w   <= 1'b1;
            id       <= '0;
            addr     <= '0;
            len      <= '0;
            burst    <= '0;
            beat     <= '0;
            err_flag <= 1'b0;
            wdata    <= '0;
            wstrb    <= '0;
            rdata    <= '0;
            rresp    <= '0;
            retry    <= 1'b0;
            in_burst <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_grant) begin
                        id       <= s_axi_awid;
                        addr     <= s_axi_awaddr;
                        len      <= s_axi_awlen;
                        burst    <= s_axi_awburst;
                        beat     <= '0;
                        err_flag <= 1'b0;
                        prio_w   <= ~prio_w;
                        state    <= WR_DATA;
                    end else if (ar_grant) begin
                        id       <= s_axi_arid;
                        addr     <= s_axi_araddr;
                        len      <= s_axi_arlen;
                        burst    <= s_axi_arburst;
                        beat     <= '0;
                        err_flag <= 1'b0;
                        prio_w   <= ~prio_w;
                        state    <= RD_WB;
                    end
                end
                WR_DATA: begin
                    if (s_axi_wvalid) begin
                        wdata <= s_axi_wdata;
                        wstrb <= s_axi_wstrb;
                        state <= WR_WB;
                    end
                end
                WR_WB: begin
                    if (retry) begin
                        retry <= 1'b0;
                    end else if (wb_done) begin
                        if (wb_err_i)
                            err_flag <= 1'b1;
                        if (beat_last) begin
                            in_burst <= 1'b0;
                            state    <= WR_RESP;
                        end else begin
                            in_burst <= 1'b1;
                            addr     <= addr_next;
                            beat     <= beat + 8'd1;
                            state    <= WR_DATA;
                        end
                    end else if (wb_rty_i) begin
                        retry <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready)
                        state <= IDLE;
                end
                RD_WB: begin
                    if (retry) begin
                        retry <= 1'b0;
                    end else if (wb_done) begin
                        // err wins over a simultaneous ack
                        if (wb_err_i) begin
                            rdata <= '0;
                            rresp <= 2'b10;
                        end else begin
                            rdata <= wb_dat_i;
                            rresp <= 2'b00;
                        end
                        in_burst <= !beat_last;
                        state    <= RD_DATA;
                    end else if (wb_rty_i) begin
                        retry <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        if (beat_last) begin
                            state <= IDLE;
                        end else begin
                            addr  <= addr_next;
                            beat  <= beat + 8'd1;
                            state <= RD_WB;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_axi_awready = aw_grant;
    assign s_axi_arready = ar_grant;
    assign s_axi_wready  = (state == WR_DATA);

    assign s_axi_bvalid  = (state == WR_RESP);
    assign s_axi_bid     = id;
    assign s_axi_bresp   = err_flag ? 2'b10 : 2'b00;

    assign s_axi_rvalid  = (state == RD_DATA);
    assign s_axi_rid     = id;
    assign s_axi_rdata   = rdata;
    assign s_axi_rresp   = rresp;
    assign s_axi_rlast   = (state == RD_DATA) && beat_last;

    assign wb_cyc_o = wb_phase || in_burst;
    assign wb_stb_o = wb_phase && !retry;
    assign wb_we_o  = (state == WR_WB);
    assign wb_sel_o = (state == WR_WB) ? wstrb :
                      (state == RD_WB) ? '1    : '0;
    assign wb_adr_o = {addr[AW-1:2], 2'b00};
    assign wb_dat_o = wdata;
    // Reserved burst type (11) behaves as INCR, including the cycle-type hint.
    assign wb_cti_o = (wb_phase && burst[0] && !burst[1] && len != 8'd0) ||
                      (wb_phase && burst == 2'b11 && len != 8'd0)
                      ? (beat_last ? 3'b111 : 3'b010) : 3'b000;
    assign wb_bte_o = 2'b00;

endmodule
